// File: rtl/hr_pkg.sv
// Shared types and constants for the heart-rhythm blocks: FSM state enum,
// default widths and the rate-class boundaries used by benches and patterns.
package hr_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } state_e;

    localparam int DEFAULT_MS_W    = 20;
    localparam int DEFAULT_COUNT_W = 16;

    localparam int TACHY_MS_MAX = 600;
    localparam int BRADY_MS_MIN = 1000;

endpackage

// File: rtl/interval_fifo.sv
// Synchronous FIFO holding queued beat intervals. DEPTH must be a power of 2
// (minimum 2). Full/empty derive from the registered level only.
module interval_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the cleared level makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/beat_pattern_gen.sv
// Programmable heartbeat source: plays queued ms intervals as beat_pulse strobes
// timed on tick_1ms. Optional macro BEAT_REPEAT_EN adds repeat_last playback.
module beat_pattern_gen
    import hr_pkg::*;
#(
    parameter int MS_W       = DEFAULT_MS_W,
    parameter int COUNT_W    = DEFAULT_COUNT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tick_1ms,
    input  logic                              enable,
`ifdef BEAT_REPEAT_EN
    input  logic                              repeat_last,
`endif
    input  logic                              int_valid,
    output logic                              int_ready,
    input  logic [MS_W-1:0]                   int_ms,
    output logic                              beat_pulse,
    output logic                              busy,
    output logic                              underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [COUNT_W-1:0]                beats_sent
);

    state_e             state_q, state_d;
    logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
    logic [MS_W-1:0]    target_q, target_d;
    logic               beat_pulse_q, beat_pulse_d;
    logic [COUNT_W-1:0] beats_sent_q, beats_sent_d;
    logic               underrun_q, underrun_d;
    logic               fifo_pop, fifo_full, fifo_empty, repeat_on;
    logic [MS_W-1:0]    fifo_head;

`ifdef BEAT_REPEAT_EN
    assign repeat_on = repeat_last;
`else
    assign repeat_on = 1'b0;
`endif

    interval_fifo #(
        .WIDTH (MS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (int_valid),
        .pop     (fifo_pop),
        .wr_data (int_ms),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        ms_cnt_d     = ms_cnt_q;
        target_d     = target_q;
        beat_pulse_d = 1'b0;
        beats_sent_d = beats_sent_q;
        underrun_d   = underrun_q;
        fifo_pop     = 1'b0;
        if (!enable) underrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    target_d = fifo_head;
                    ms_cnt_d = '0;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d  = IDLE;
                    ms_cnt_d = '0;
                end else if (ms_cnt_q == target_q) begin
                    beat_pulse_d = 1'b1;
                    beats_sent_d = beats_sent_q + COUNT_W'(1);
                    ms_cnt_d     = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        target_d = fifo_head;
                    end else if (!repeat_on) begin
                        state_d    = IDLE;
                        underrun_d = 1'b1;
                    end
                end else if (tick_1ms && !beat_pulse_q && (ms_cnt_q != '1)) begin
                    // Ticks landing on the beat cycle are dropped so the next interval starts clean.
                    ms_cnt_d = ms_cnt_q + MS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ms_cnt_q     <= '0;
            target_q     <= '0;
            beat_pulse_q <= 1'b0;
            beats_sent_q <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_cnt_q     <= ms_cnt_d;
            target_q     <= target_d;
            beat_pulse_q <= beat_pulse_d;
            beats_sent_q <= beats_sent_d;
            underrun_q   <= underrun_d;
        end
    end

    assign int_ready  = !fifo_full;
    assign beat_pulse = beat_pulse_q;
    assign busy       = (state_q == COUNT);
    assign underrun   = underrun_q;
    assign beats_sent = beats_sent_q;

endmodule

// File: tb/tb_beat_pattern_gen.sv
// Directed self-checking bench for beat_pattern_gen; define BEAT_REPEAT_EN to
// also exercise repeat_last playback.
module tb_beat_pattern_gen;

    localparam int MS_W       = 20;
    localparam int COUNT_W    = 16;
    localparam int FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               tick_1ms;
    logic               enable;
    logic               int_valid;
    logic               int_ready;
    logic [MS_W-1:0]    int_ms;
    logic               beat_pulse;
    logic               busy;
    logic               underrun;
    logic [2:0]         fifo_level;
    logic [COUNT_W-1:0] beats_sent;
`ifdef BEAT_REPEAT_EN
    logic               repeat_last;
`endif

    int total = 0;
    int bad   = 0;
    int beat_seen = 0;

    beat_pattern_gen #(
        .MS_W       (MS_W),
        .COUNT_W    (COUNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1ms    (tick_1ms),
        .enable      (enable),
`ifdef BEAT_REPEAT_EN
        .repeat_last (repeat_last),
`endif
        .int_valid   (int_valid),
        .int_ready   (int_ready),
        .int_ms      (int_ms),
        .beat_pulse  (beat_pulse),
        .busy        (busy),
        .underrun    (underrun),
        .fifo_level  (fifo_level),
        .beats_sent  (beats_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (beat_pulse === 1'b1) beat_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input int v);
        int_valid = 1'b1;
        int_ms    = MS_W'(v);
        step();
        int_valid = 1'b0;
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1;
            step();
            tick_1ms = 1'b0;
            repeat (gap - 1) step();
        end
    endtask

    // The final tick of an interval: beat must appear exactly 2 clk later, for one cycle.
    task automatic tick_expect_beat(input string tag);
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
        check({tag, "_early"}, beat_pulse, 1'b0);
        step();
        check(tag, beat_pulse, 1'b1);
        step();
        check({tag, "_width"}, beat_pulse, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_beat"},  beat_pulse, 1'b0);
        check({tag, "_busy"},  busy, 1'b0);
        check({tag, "_under"}, underrun, 1'b0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_sent"},  beats_sent, 0);
        check({tag, "_ready"}, int_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int iv[4];
        iv = '{500, 1200, 600, 1000};
        rst = 1'b1; tick_1ms = 1'b0; enable = 1'b0; int_valid = 1'b0; int_ms = '0;
`ifdef BEAT_REPEAT_EN
        repeat_last = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check_reset("rst0");

        // Single 800 ms interval; empty FIFO at first load must not flag underrun.
        enable = 1'b1;
        repeat (3) step();
        check("t1_noload_under", underrun, 1'b0);
        check("t1_noload_busy", busy, 1'b0);
        push(800);
        check("t1_level1", fifo_level, 1);
        step();
        check("t1_busy", busy, 1'b1);
        check("t1_level0", fifo_level, 0);
        base = beat_seen;
        run_ticks(799, 10);
        check("t1_quiet", beat_seen - base, 0);
        tick_expect_beat("t1_beat");
        check("t1_sent", beats_sent, 1);
        check("t1_idle", busy, 1'b0);
        check("t1_under", underrun, 1'b1);

        // Four intervals across the rate-class boundaries.
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) push(iv[k]);
        check("t2_level", fifo_level, 3);
        for (int k = 0; k < 4; k++) begin
            base = beat_seen;
            run_ticks(iv[k] - 1, 4);
            check("t2_quiet", beat_seen - base, 0);
            tick_expect_beat("t2_beat");
        end
        check("t2_sent", beats_sent, 4);
        check("t2_under", underrun, 1'b1);
        check("t2_idle", busy, 1'b0);
        enable = 1'b0;
        step();
        check("t2_under_clr", underrun, 1'b0);

        // Intervals 1,0,1: back-to-back beats, and a tick on a beat cycle is dropped.
        do_reset();
        enable = 1'b0;
        push(1);
        push(0);
        push(1);
        enable = 1'b1;
        step();
        check("t6_busy", busy, 1'b1);
        check("t6_level", fifo_level, 2);
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
        check("t6_early", beat_pulse, 1'b0);
        step();
        check("t6_beat1", beat_pulse, 1'b1);
        step();
        check("t6_beat0ms", beat_pulse, 1'b1);
        check("t6_level0", fifo_level, 0);
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
        check("t6_ign_a", beat_pulse, 1'b0);
        step();
        check("t6_ign_b", beat_pulse, 1'b0);
        check("t6_ign_busy", busy, 1'b1);
        step();
        tick_expect_beat("t6_beat3");
        check("t6_sent", beats_sent, 3);
        check("t6_under", underrun, 1'b1);

        // Fill with enable low, then full + push + pop in the same cycle.
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t3_ready_full", int_ready, 1'b0);
            push(100 + i);
            if (i == 3) check("t3_level4", fifo_level, 4);
        end
        check("t3_level_keep", fifo_level, 4);
        enable = 1'b1;
        push(999);
        check("t3_pushpop_full", fifo_level, 3);

        // Abort at ms_cnt=300 of a 700 interval, then resume with the next entry.
        do_reset();
        enable = 1'b0;
        push(700);
        push(900);
        push(400);
        enable = 1'b1;
        step();
        check("t4_busy", busy, 1'b1);
        base = beat_seen;
        run_ticks(300, 3);
        enable = 1'b0;
        step();
        check("t4_abort_busy", busy, 1'b0);
        check("t4_abort_under", underrun, 1'b0);
        check("t4_abort_level", fifo_level, 2);
        repeat (5) step();
        check("t4_nobeat", beat_seen - base, 0);
        enable = 1'b1;
        step();
        check("t4_reload_busy", busy, 1'b1);
        check("t4_reload_level", fifo_level, 1);
        run_ticks(899, 3);
        check("t4_quiet", beat_seen - base, 0);
        tick_expect_beat("t4_beat");
        check("t4_next_busy", busy, 1'b1);
        check("t4_sent", beats_sent, 1);

        // Reset mid-count with three entries queued.
        do_reset();
        enable = 1'b1;
        push(50);
        push(20);
        push(30);
        push(40);
        check("t5_level", fifo_level, 3);
        run_ticks(10, 3);
        do_reset();
        check_reset("t5_rst");
        base = beat_seen;
        run_ticks(60, 3);
        check("t5_nobeat", beat_seen - base, 0);
        check("t5_idle", busy, 1'b0);

`ifdef BEAT_REPEAT_EN
        // repeat_last replays the last interval, then stops once dropped.
        do_reset();
        enable = 1'b1;
        repeat_last = 1'b1;
        push(5);
        step();
        for (int r = 0; r < 3; r++) begin
            run_ticks(4, 3);
            tick_expect_beat("rp_beat");
            check("rp_busy", busy, 1'b1);
            check("rp_under", underrun, 1'b0);
        end
        repeat_last = 1'b0;
        run_ticks(4, 3);
        tick_expect_beat("rp_last");
        check("rp_end_busy", busy, 1'b0);
        check("rp_end_under", underrun, 1'b1);
        check("rp_sent", beats_sent, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
